// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus controller: RV32I width codes,
// requester identifiers and the access-legality rule.
package mem_bus_pkg;

  localparam logic [2:0] F3_LB    = 3'b000;
  localparam logic [2:0] F3_LH    = 3'b001;
  localparam logic [2:0] F3_LW    = 3'b010;
  localparam logic [2:0] F3_LBU   = 3'b100;
  localparam logic [2:0] F3_LHU   = 3'b101;
  localparam logic [2:0] F3_FETCH = 3'b010;

  typedef enum logic {
    SRC_IF,
    SRC_LS
  } src_t;

  // Fetches are checked as plain word loads.
  function automatic logic is_legal(input logic        write,
                                    input logic [2:0]  funct3,
                                    input logic [31:0] addr);
    logic ok;
    case (funct3)
      F3_LB, F3_LBU: ok = 1'b1;
      F3_LH, F3_LHU: ok = (addr[0] == 1'b0);
      F3_LW:         ok = (addr[1:0] == 2'b00);
      default:       ok = 1'b0;
    endcase
    if (write && funct3[2]) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/mem_bus_arb.sv
// Two-way arbiter: load/store has priority, fetch is forced through after
// losing STARVE_LIMIT consecutive cycles.
module mem_bus_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_valid,
  input  logic ls_valid,
  output logic grant_if,
  output logic grant_ls
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (rst_n) begin
      if (if_valid && (!ls_valid || starve_cnt == LIMIT)) grant_if = 1'b1;
      else if (ls_valid)                                   grant_ls = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (if_valid && !grant_if) begin
      if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-port owner: arbitrates fetch vs load/store, screens illegal accesses
// and returns tagged responses one cycle after issue.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_fault,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic        ls_req_write,
  input  logic [2:0]  ls_req_funct3,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_rsp_valid,
  output logic [31:0] ls_rsp_data,
  output logic        ls_rsp_fault,
  output logic        mem_write,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_read_address,
  input  logic [31:0] mem_read_data
);

  logic        grant_if, grant_ls, granted;
  logic [31:0] sel_addr;
  logic [2:0]  sel_funct3;
  logic        sel_write, sel_legal;

  logic        fl_valid, fl_fault, fl_store;
  src_t        fl_src;

  mem_bus_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_valid (if_req_valid),
    .ls_valid (ls_req_valid),
    .grant_if (grant_if),
    .grant_ls (grant_ls)
  );

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;
  assign granted      = grant_if | grant_ls;

  always_comb begin
    sel_addr          = grant_if ? if_addr : ls_addr;
    sel_funct3        = grant_if ? F3_FETCH : ls_req_funct3;
    sel_write         = grant_ls & ls_req_write;
    sel_legal         = is_legal(sel_write, sel_funct3, sel_addr);
    mem_write         = 1'b0;
    mem_funct3        = F3_FETCH;
    mem_write_address = '0;
    mem_write_data    = '0;
    mem_read_address  = '0;
    if (granted && sel_legal) begin
      mem_read_address = sel_addr;
      mem_funct3       = sel_funct3;
      if (sel_write) begin
        mem_write         = 1'b1;
        mem_write_address = sel_addr;
        mem_write_data    = ls_wdata;
      end
    end
  end

  // Memory read data lands one cycle after issue; these flags tag it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fl_valid <= 1'b0;
      fl_src   <= SRC_IF;
      fl_fault <= 1'b0;
      fl_store <= 1'b0;
    end else begin
      fl_valid <= granted;
      fl_src   <= grant_if ? SRC_IF : SRC_LS;
      fl_fault <= granted & ~sel_legal;
      fl_store <= granted & sel_write;
    end
  end

  always_comb begin
    if_rsp_valid = fl_valid && (fl_src == SRC_IF);
    ls_rsp_valid = fl_valid && (fl_src == SRC_LS);
    if_rsp_fault = if_rsp_valid & fl_fault;
    ls_rsp_fault = ls_rsp_valid & fl_fault;
    if_rsp_data  = (if_rsp_valid && !fl_fault) ? mem_read_data : '0;
    ls_rsp_data  = (ls_rsp_valid && !fl_fault && !fl_store) ? mem_read_data : '0;
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl with a byte-lane memory and a
// transaction-level reference model.
module tb_mem_bus_ctrl;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid = 1'b0, if_req_ready;
  logic [31:0] if_addr = '0;
  logic        if_rsp_valid, if_rsp_fault;
  logic [31:0] if_rsp_data;
  logic        ls_req_valid = 1'b0, ls_req_ready, ls_req_write = 1'b0;
  logic [2:0]  ls_req_funct3 = 3'b010;
  logic [31:0] ls_addr = '0, ls_wdata = '0;
  logic        ls_rsp_valid, ls_rsp_fault;
  logic [31:0] ls_rsp_data;
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_write_address, mem_write_data, mem_read_address;
  logic [31:0] mem_read_data = '0;

  int checks = 0;
  int errors = 0;

  mem_bus_ctrl #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_fault(if_rsp_fault),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_write(ls_req_write),
    .ls_req_funct3(ls_req_funct3), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data), .ls_rsp_fault(ls_rsp_fault),
    .mem_write(mem_write), .mem_funct3(mem_funct3), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_read_address(mem_read_address),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 29 + 7) ^ (i >> 3));
  endfunction

  function automatic logic [31:0] extend(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3,
                                         input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b100:  return {24'h0, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b101:  return {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  // Byte-lane memory with one-cycle registered read, refilled while in reset.
  logic [7:0] tb_mem [256];
  logic [7:0] ra, wa;
  assign ra = mem_read_address[7:0];
  assign wa = mem_write_address[7:0];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= init_byte(i);
    end else begin
      mem_read_data <= extend(tb_mem[ra], tb_mem[ra + 8'd1], tb_mem[ra + 8'd2],
                              tb_mem[ra + 8'd3], mem_funct3);
      if (mem_write) begin
        tb_mem[wa] <= mem_write_data[7:0];
        if (mem_funct3[1:0] != 2'b00) tb_mem[wa + 8'd1] <= mem_write_data[15:8];
        if (mem_funct3[1:0] == 2'b10) begin
          tb_mem[wa + 8'd2] <= mem_write_data[23:16];
          tb_mem[wa + 8'd3] <= mem_write_data[31:24];
        end
      end
    end
  end

  // Reference model: byte array, starvation count, one expected response.
  logic [7:0]  m_mem [256];
  int          m_starve;
  logic        pend_v, pend_is_if, pend_fault;
  logic [31:0] pend_data;
  logic        nx_v, nx_is_if, nx_fault;
  logic [31:0] nx_data;
  logic        exp_if_ready, exp_ls_ready, exp_mw;
  logic [2:0]  exp_mf3;
  logic [31:0] exp_mra, exp_mwa, exp_mwd;
  int          m_wbytes;

  function automatic bit model_ok(input bit is_fetch, input bit wr,
                                  input logic [2:0] f3, input logic [31:0] a);
    if (is_fetch) return (a % 4) == 0;
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b0;
    if (wr && f3 >= 3'b100) return 1'b0;
    return (a % (32'd1 << f3[1:0])) == 0;
  endfunction

  function automatic void model_reset();
    m_starve = 0;
    pend_v = 1'b0; pend_is_if = 1'b0; pend_fault = 1'b0; pend_data = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = init_byte(i);
  endfunction

  function automatic void model_eval();
    logic [31:0] a;
    logic [2:0]  f3;
    bit          wr, ok;
    exp_if_ready = if_req_valid && (!ls_req_valid || m_starve == LIMIT);
    exp_ls_ready = ls_req_valid && !exp_if_ready;
    exp_mw = 1'b0; exp_mf3 = 3'b010; exp_mra = '0; exp_mwa = '0; exp_mwd = '0;
    m_wbytes = 0;
    nx_v = exp_if_ready || exp_ls_ready;
    nx_is_if = exp_if_ready; nx_fault = 1'b0; nx_data = '0;
    if (nx_v) begin
      a  = exp_if_ready ? if_addr : ls_addr;
      f3 = exp_if_ready ? 3'b010 : ls_req_funct3;
      wr = exp_ls_ready && ls_req_write;
      ok = model_ok(exp_if_ready, wr, f3, a);
      nx_fault = !ok;
      if (ok) begin
        exp_mra = a; exp_mf3 = f3;
        if (wr) begin
          exp_mw = 1'b1; exp_mwa = a; exp_mwd = ls_wdata;
          m_wbytes = 1 << f3[1:0];
        end else begin
          nx_data = extend(m_mem[a & 255], m_mem[(a + 1) & 255], m_mem[(a + 2) & 255],
                           m_mem[(a + 3) & 255], f3);
        end
      end
    end
  endfunction

  function automatic void model_commit();
    if (if_req_valid && !exp_if_ready) begin
      if (m_starve < LIMIT) m_starve++;
    end else begin
      m_starve = 0;
    end
    for (int k = 0; k < m_wbytes; k++)
      m_mem[(exp_mwa + k) & 255] = exp_mwd[8*k +: 8];
    pend_v = nx_v; pend_is_if = nx_is_if; pend_fault = nx_fault; pend_data = nx_data;
  endfunction

  task automatic drive(input logic ifv, input logic [31:0] ifa, input logic lsv,
                       input logic lsw, input logic [2:0] f3, input logic [31:0] lsa,
                       input logic [31:0] wd);
    if_req_valid = ifv; if_addr = ifa;
    ls_req_valid = lsv; ls_req_write = lsw; ls_req_funct3 = f3;
    ls_addr = lsa; ls_wdata = wd;
    model_eval();
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 3'b010, '0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    drive(1'b1, 32'h4, 1'b1, 1'b0, 3'b010, 32'h10, '0);
    @(negedge clk);
    checks++; if (if_req_ready !== 1'b0) begin errors++; $display("FAIL reset_if_ready got %b exp 0", if_req_ready); end
    checks++; if (ls_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ls_ready got %b exp 0", ls_req_ready); end
    checks++; if ({if_rsp_valid, if_rsp_fault, if_rsp_data} !== 34'h0) begin errors++; $display("FAIL reset_if_rsp got %b/%b/%h exp 0", if_rsp_valid, if_rsp_fault, if_rsp_data); end
    checks++; if ({ls_rsp_valid, ls_rsp_fault, ls_rsp_data} !== 34'h0) begin errors++; $display("FAIL reset_ls_rsp got %b/%b/%h exp 0", ls_rsp_valid, ls_rsp_fault, ls_rsp_data); end
    checks++; if ({mem_write, mem_funct3, mem_read_address, mem_write_address, mem_write_data} !== {1'b0, 3'b010, 96'h0}) begin errors++; $display("FAIL reset_mem_idle got %b %b %h %h %h exp idle", mem_write, mem_funct3, mem_read_address, mem_write_address, mem_write_data); end
    do_reset();
    // Load granted, then reset lands before its response would appear.
    drive(1'b0, '0, 1'b1, 1'b0, 3'b010, 32'h10, '0);
    @(negedge clk);
    checks++; if (ls_req_ready !== 1'b1) begin errors++; $display("FAIL midload_grant got %b exp 1", ls_req_ready); end
    @(posedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    idle();
    @(negedge clk);
    checks++; if ({ls_rsp_valid, ls_rsp_data, ls_rsp_fault, if_rsp_valid} !== 35'h0) begin errors++; $display("FAIL midload_dropped got %b/%h/%b/%b exp 0", ls_rsp_valid, ls_rsp_data, ls_rsp_fault, if_rsp_valid); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle();
    @(negedge clk);
    checks++; if ({ls_rsp_valid, if_rsp_valid, mem_write} !== 3'b000) begin errors++; $display("FAIL postreset_quiet got %b exp 000", {ls_rsp_valid, if_rsp_valid, mem_write}); end
    tick();
    drive(1'b1, 32'h8, 1'b0, 1'b0, 3'b010, '0, '0);
    @(negedge clk);
    checks++; if (if_req_ready !== 1'b1) begin errors++; $display("FAIL postreset_first_grant got %b exp 1", if_req_ready); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== pend_data) begin errors++; $display("FAIL postreset_fetch got %b/%h exp 1/%h", if_rsp_valid, if_rsp_data, pend_data); end
    tick();
  endtask

  task automatic test_fetch();
    logic [31:0] word;
    do_reset();
    word = {init_byte(7), init_byte(6), init_byte(5), init_byte(4)};
    drive(1'b1, 32'h4, 1'b0, 1'b0, 3'b010, '0, '0);
    @(negedge clk);
    checks++; if (if_req_ready !== 1'b1 || ls_req_ready !== 1'b0) begin errors++; $display("FAIL fetch_ready got %b%b exp 10", if_req_ready, ls_req_ready); end
    checks++; if (mem_read_address !== 32'h4 || mem_funct3 !== 3'b010 || mem_write !== 1'b0) begin errors++; $display("FAIL fetch_issue got %h/%b/%b exp 4/010/0", mem_read_address, mem_funct3, mem_write); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (if_rsp_valid !== 1'b1 || if_rsp_fault !== 1'b0 || if_rsp_data !== word) begin errors++; $display("FAIL fetch_rsp got %b/%b/%h exp 1/0/%h", if_rsp_valid, if_rsp_fault, if_rsp_data, word); end
    checks++; if (ls_rsp_valid !== 1'b0) begin errors++; $display("FAIL fetch_no_ls_rsp got %b exp 0", ls_rsp_valid); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (if_rsp_valid !== 1'b0) begin errors++; $display("FAIL fetch_rsp_one_cycle got %b exp 0", if_rsp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w10, w0;
    do_reset();
    w10 = {init_byte(19), init_byte(18), init_byte(17), init_byte(16)};
    w0  = {init_byte(3), init_byte(2), init_byte(1), init_byte(0)};
    drive(1'b0, '0, 1'b1, 1'b0, 3'b010, 32'h10, '0);
    @(negedge clk);
    checks++; if (ls_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ls_grant got %b exp 1", ls_req_ready); end
    tick();
    drive(1'b1, 32'h0, 1'b0, 1'b0, 3'b010, '0, '0);
    @(negedge clk);
    checks++; if (if_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_if_grant got %b exp 1", if_req_ready); end
    checks++; if (ls_rsp_valid !== 1'b1 || ls_rsp_data !== w10 || if_rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_ls_rsp got %b/%h if %b exp 1/%h if 0", ls_rsp_valid, ls_rsp_data, if_rsp_valid, w10); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== w0 || ls_rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_if_rsp got %b/%h ls %b exp 1/%h ls 0", if_rsp_valid, if_rsp_data, ls_rsp_valid, w0); end
    tick();
  endtask

  task automatic test_starvation();
    logic [9:0] pattern;
    pattern = 10'b1000010000;  // LSB first: LS,LS,LS,LS,IF,LS,LS,LS,LS,IF
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h20, 1'b1, 1'b0, 3'b010, 32'h40, '0);
      @(negedge clk);
      checks++; if (if_req_ready !== pattern[i] || ls_req_ready !== !pattern[i]) begin errors++; $display("FAIL starve_grant_%0d got if%b ls%b exp if%b", i, if_req_ready, ls_req_ready, pattern[i]); end
      if (i > 0) begin
        checks++; if (if_rsp_valid !== pattern[i-1] || ls_rsp_valid !== !pattern[i-1]) begin errors++; $display("FAIL starve_rsp_%0d got if%b ls%b exp if%b", i, if_rsp_valid, ls_rsp_valid, pattern[i-1]); end
      end
      tick();
    end
  endtask

  task automatic test_misalign();
    logic        t_if   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic        t_wr   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  t_f3   [4] = '{3'b010, 3'b001, 3'b010, 3'b010};
    logic [31:0] t_addr [4] = '{32'h102, 32'h101, 32'h3, 32'h2};
    logic [31:0] w0;
    do_reset();
    w0 = {init_byte(3), init_byte(2), init_byte(1), init_byte(0)};
    for (int i = 0; i < 4; i++) begin
      drive(t_if[i], t_addr[i], !t_if[i], t_wr[i], t_f3[i], t_addr[i], 32'hDEADBEEF);
      @(negedge clk);
      checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL misalign_nowrite_%0d got %b exp 0", i, mem_write); end
      tick();
      idle();
      @(negedge clk);
      if (t_if[i]) begin
        checks++; if ({if_rsp_valid, if_rsp_fault, if_rsp_data} !== {2'b11, 32'h0}) begin errors++; $display("FAIL misalign_rsp_%0d got %b/%b/%h exp 1/1/0", i, if_rsp_valid, if_rsp_fault, if_rsp_data); end
      end else begin
        checks++; if ({ls_rsp_valid, ls_rsp_fault, ls_rsp_data} !== {2'b11, 32'h0}) begin errors++; $display("FAIL misalign_rsp_%0d got %b/%b/%h exp 1/1/0", i, ls_rsp_valid, ls_rsp_fault, ls_rsp_data); end
      end
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b0, 3'b010, 32'h0, '0);
    tick();
    idle();
    @(negedge clk);
    checks++; if (ls_rsp_valid !== 1'b1 || ls_rsp_fault !== 1'b0 || ls_rsp_data !== w0) begin errors++; $display("FAIL misalign_readback got %b/%b/%h exp 1/0/%h", ls_rsp_valid, ls_rsp_fault, ls_rsp_data, w0); end
    tick();
  endtask

  task automatic test_subword_store();
    do_reset();
    drive(1'b0, '0, 1'b1, 1'b1, 3'b000, 32'h13, 32'h000000AB);
    @(negedge clk);
    checks++; if ({mem_write, mem_funct3, mem_write_address, mem_write_data} !== {1'b1, 3'b000, 32'h13, 32'hAB}) begin errors++; $display("FAIL sb_issue got %b/%b/%h/%h exp 1/000/13/ab", mem_write, mem_funct3, mem_write_address, mem_write_data); end
    tick();
    drive(1'b0, '0, 1'b1, 1'b0, 3'b100, 32'h13, '0);
    @(negedge clk);
    checks++; if ({ls_rsp_valid, ls_rsp_fault, ls_rsp_data} !== {2'b10, 32'h0}) begin errors++; $display("FAIL sb_rsp got %b/%b/%h exp 1/0/0", ls_rsp_valid, ls_rsp_fault, ls_rsp_data); end
    tick();
    drive(1'b0, '0, 1'b1, 1'b0, 3'b000, 32'h13, '0);
    @(negedge clk);
    checks++; if (ls_rsp_valid !== 1'b1 || ls_rsp_data !== 32'h000000AB) begin errors++; $display("FAIL lbu_rsp got %b/%h exp 1/000000ab", ls_rsp_valid, ls_rsp_data); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (ls_rsp_valid !== 1'b1 || ls_rsp_data !== 32'hFFFFFFAB) begin errors++; $display("FAIL lb_rsp got %b/%h exp 1/ffffffab", ls_rsp_valid, ls_rsp_data); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] ia, la;
    logic [2:0]  f3;
    logic [31:0] e_ifd, e_lsd;
    logic        e_ifv, e_lsv;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      f3 = 3'($urandom_range(0, 7));
      ia = 32'($urandom_range(0, 255));
      la = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) ia = ia & ~32'h3;
      if ($urandom_range(0, 1) != 0) la = la & ~((32'd1 << f3[1:0]) - 32'd1);
      drive(1'($urandom_range(0, 1)), ia, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 1)), f3, la, $urandom);
      @(negedge clk);
      e_ifv = pend_v && pend_is_if;
      e_lsv = pend_v && !pend_is_if;
      e_ifd = e_ifv ? pend_data : '0;
      e_lsd = e_lsv ? pend_data : '0;
      checks++; if ({if_req_ready, ls_req_ready} !== {exp_if_ready, exp_ls_ready}) begin errors++; $display("FAIL rnd_grant_%0d got %b%b exp %b%b", i, if_req_ready, ls_req_ready, exp_if_ready, exp_ls_ready); end
      checks++; if ({mem_write, mem_funct3, mem_read_address, mem_write_address, mem_write_data} !== {exp_mw, exp_mf3, exp_mra, exp_mwa, exp_mwd}) begin errors++; $display("FAIL rnd_mem_%0d got %b %b %h %h %h exp %b %b %h %h %h", i, mem_write, mem_funct3, mem_read_address, mem_write_address, mem_write_data, exp_mw, exp_mf3, exp_mra, exp_mwa, exp_mwd); end
      checks++; if ({if_rsp_valid, if_rsp_fault, if_rsp_data} !== {e_ifv, e_ifv & pend_fault, e_ifd}) begin errors++; $display("FAIL rnd_if_rsp_%0d got %b/%b/%h exp %b/%b/%h", i, if_rsp_valid, if_rsp_fault, if_rsp_data, e_ifv, e_ifv & pend_fault, e_ifd); end
      checks++; if ({ls_rsp_valid, ls_rsp_fault, ls_rsp_data} !== {e_lsv, e_lsv & pend_fault, e_lsd}) begin errors++; $display("FAIL rnd_ls_rsp_%0d got %b/%b/%h exp %b/%b/%h", i, ls_rsp_valid, ls_rsp_fault, ls_rsp_data, e_lsv, e_lsv & pend_fault, e_lsd); end
      checks++; if (if_rsp_valid === 1'b1 && ls_rsp_valid === 1'b1) begin errors++; $display("FAIL rnd_both_rsp_%0d got 11 exp not both", i); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_back_to_back();
    test_starvation();
    test_misalign();
    test_subword_store();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
